serdesphy_ana_pll_lock_detector: RTL and testbench

Frequency lock detector for the SerDes PHY PLL, clocked by the 240 MHz VCO output alongside the ÷10 feedback divider. It counts VCO cycles between rising edges of the 24 MHz reference clock and checks each count against the expected ratio (10). It asserts `locked` after a run of in-tolerance periods and drops it after a run of out-of-tolerance periods. `locked` gates the TX/RX bring-up sequencer.

---
 rtl/serdesphy_pll_pkg.sv | 19 +
 rtl/serdesphy_sync_2ff.sv | 24 ++
 rtl/serdesphy_ana_pll_lock_detector.sv | 161 ++++++++++++++++
 tb/tb_serdesphy_ana_pll_lock_detector.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/serdesphy_pll_pkg.sv
// Shared PLL definitions: lock-detector state encoding and the default
// ratios used by both the lock detector and the feedback divider.
package serdesphy_pll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_ACQUIRE = 2'd2,
    ST_LOCKED  = 2'd3
  } lock_state_e;

  localparam int unsigned PLL_DIV_RATIO      = 10;
  localparam int unsigned PLL_EXPECTED_COUNT = PLL_DIV_RATIO;
  localparam int unsigned PLL_TOLERANCE      = 1;
  localparam int unsigned PLL_LOCK_CYCLES    = 16;
  localparam int unsigned PLL_UNLOCK_CYCLES  = 4;
  localparam int unsigned PLL_CNT_W          = 6;

endpackage

// File: rtl/serdesphy_sync_2ff.sv
// Two-flop synchronizer for asynchronous single- or multi-bit level inputs.
module serdesphy_sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;

  // NOTE: non-blocking assignments keep s1 -> q a genuine two-stage pipeline.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/serdesphy_ana_pll_lock_detector.sv
// PLL frequency lock detector: counts VCO cycles per reference period and
// tracks lock with hysteresis (LOCK_CYCLES good in, UNLOCK_CYCLES bad out).
module serdesphy_ana_pll_lock_detector
  import serdesphy_pll_pkg::*;
#(
  parameter int unsigned EXPECTED_COUNT = PLL_EXPECTED_COUNT,
  parameter int unsigned TOLERANCE      = PLL_TOLERANCE,
  parameter int unsigned LOCK_CYCLES    = PLL_LOCK_CYCLES,
  parameter int unsigned UNLOCK_CYCLES  = PLL_UNLOCK_CYCLES,
  parameter int unsigned CNT_W          = PLL_CNT_W
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             ref_clk,
  output logic             locked,
  output logic             lock_lost,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period_count
);

  localparam int unsigned GOOD_W = $clog2(LOCK_CYCLES + 1);
  localparam int unsigned BAD_W  = $clog2(UNLOCK_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] WIN_HI  = CNT_W'(EXPECTED_COUNT + TOLERANCE);
  // Lower bound clamps at zero so the window test stays purely unsigned.
  localparam logic [CNT_W-1:0] WIN_LO  = (EXPECTED_COUNT > TOLERANCE) ?
                                         CNT_W'(EXPECTED_COUNT - TOLERANCE) : '0;

  lock_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_run;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [BAD_W-1:0]  bad_q, bad_d;
  logic             locked_d, lock_lost_d, meas_valid_d;
  logic [CNT_W-1:0] period_d;

  logic ref_s2, ref_s3, ref_edge;
  logic timeout, meas_good, ev_good, ev_bad;

  serdesphy_sync_2ff #(.WIDTH(1)) u_ref_sync (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .d      (ref_clk),
    .q      (ref_s2)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) ref_s3 <= 1'b0;
    else        ref_s3 <= ref_s2;
  end

  assign ref_edge = ref_s2 & ~ref_s3;

  // A reference edge always takes priority over saturation: one event only.
  assign timeout   = (cnt_q == CNT_MAX) && !ref_edge;
  assign cnt_run   = (ref_edge || cnt_q == CNT_MAX) ? CNT_ONE : cnt_q + CNT_ONE;
  assign meas_good = (cnt_q >= WIN_LO) && (cnt_q <= WIN_HI);
  assign ev_good   = ref_edge && meas_good;
  assign ev_bad    = (ref_edge && !meas_good) || timeout;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      good_q       <= '0;
      bad_q        <= '0;
      locked       <= 1'b0;
      lock_lost    <= 1'b0;
      meas_valid   <= 1'b0;
      period_count <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
      locked       <= locked_d;
      lock_lost    <= lock_lost_d;
      meas_valid   <= meas_valid_d;
      period_count <= period_d;
    end
  end

  // NOTE: every target gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    good_d       = good_q;
    bad_d        = bad_q;
    locked_d     = locked;
    lock_lost_d  = 1'b0;
    meas_valid_d = 1'b0;
    period_d     = period_count;

    if (!enable) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      good_d   = '0;
      bad_d    = '0;
      locked_d = 1'b0;
      period_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_ARM;
        end

        // The arming edge only aligns the counter; it is never judged.
        ST_ARM: begin
          cnt_d = cnt_run;
          if (ref_edge) state_d = ST_ACQUIRE;
        end

        ST_ACQUIRE: begin
          cnt_d = cnt_run;
          if (ref_edge) begin
            meas_valid_d = 1'b1;
            period_d     = cnt_q;
          end
          if (ev_good) begin
            if (good_q == GOOD_W'(LOCK_CYCLES - 1)) begin
              state_d  = ST_LOCKED;
              good_d   = GOOD_W'(LOCK_CYCLES);
              bad_d    = '0;
              locked_d = 1'b1;
            end else begin
              good_d = good_q + GOOD_W'(1);
            end
          end else if (ev_bad) begin
            good_d = '0;
          end
        end

        ST_LOCKED: begin
          cnt_d = cnt_run;
          if (ref_edge) begin
            meas_valid_d = 1'b1;
            period_d     = cnt_q;
          end
          if (ev_bad) begin
            if (bad_q == BAD_W'(UNLOCK_CYCLES - 1)) begin
              state_d     = ST_ACQUIRE;
              bad_d       = BAD_W'(UNLOCK_CYCLES);
              good_d      = '0;
              locked_d    = 1'b0;
              lock_lost_d = 1'b1;
            end else begin
              bad_d = bad_q + BAD_W'(1);
            end
          end else if (ev_good) begin
            bad_d = '0;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serdesphy_ana_pll_lock_detector.sv
// Scoreboard bench for the PLL lock detector: stimulus pushes expected
// measurement/lock-loss events, a monitor pops them as the DUT reports.
module tb_serdesphy_ana_pll_lock_detector;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       ref_clk;
  logic       locked;
  logic       lock_lost;
  logic       meas_valid;
  logic [5:0] period_count;

  typedef struct packed {
    logic       meas;
    logic [5:0] period;
    logic       lk;
    logic       ll;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   last_len = 0;

  serdesphy_ana_pll_lock_detector dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .enable       (enable),
    .ref_clk      (ref_clk),
    .locked       (locked),
    .lock_lost    (lock_lost),
    .meas_valid   (meas_valid),
    .period_count (period_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // One reference rising edge; optionally pushes the expected measurement of
  // the previous period, then holds the pulse for next_len cycles.
  // next_len == 0 leaves ref_clk low afterwards (quiet reference).
  task automatic ref_edge_send(input bit meas, input bit exp_lk, input bit exp_ll,
                               input int next_len);
    exp_t e;
    if (meas) begin
      e.meas   = 1'b1;
      e.period = 6'(last_len);
      e.lk     = exp_lk;
      e.ll     = exp_ll;
      exp_q.push_back(e);
    end
    @(negedge clk_in);
    ref_clk = 1'b1;
    if (next_len == 0) begin
      cycles(5);
      ref_clk = 1'b0;
    end else begin
      cycles(next_len / 2);
      ref_clk = 1'b0;
      cycles(next_len - next_len / 2 - 1);
    end
    last_len = next_len;
  endtask

  // Monitor: every measurement or lock-loss pulse must match the queue head.
  always @(negedge clk_in) begin
    if (rst_n && (meas_valid || lock_lost)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: meas_valid=%0d lock_lost=%0d period=%0d at %0t",
                 meas_valid, lock_lost, period_count, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_meas_valid", 32'(meas_valid), 32'(e.meas));
        if (e.meas) check("sb_period", 32'(period_count), 32'(e.period));
        check("sb_locked", 32'(locked), 32'(e.lk));
        check("sb_lock_lost", 32'(lock_lost), 32'(e.ll));
      end
    end
  end

  initial begin
    int d_seq[8];
    exp_t e;
    d_seq = '{10, 13, 13, 10, 13, 13, 13, 10};
    rst_n   = 1'b0;
    enable  = 1'b0;
    ref_clk = 1'b0;
    cycles(3);
    check("rst_locked", 32'(locked), 0);
    check("rst_lock_lost", 32'(lock_lost), 0);
    check("rst_meas_valid", 32'(meas_valid), 0);
    check("rst_period", 32'(period_count), 0);
    rst_n = 1'b1;
    cycles(2);
    enable = 1'b1;
    cycles(3);

    // Nominal period 10: arming edge unmeasured, lock on 16th measurement.
    ref_edge_send(0, 0, 0, 10);
    for (int i = 1; i <= 16; i++) ref_edge_send(1, i == 16, 0, 10);

    // Four periods of 13 while locked: unlock with one lock_lost on the 4th.
    ref_edge_send(1, 1, 0, 13);
    for (int k = 1; k <= 4; k++) ref_edge_send(1, k < 4, k == 4, (k < 4) ? 13 : 11);

    // Alternating 11/9 with a single 12 at measurement 10: lock at 26.
    for (int m = 1; m <= 26; m++) begin
      int nl;
      if (m == 26)           nl = 10;
      else if (m + 1 == 10)  nl = 12;
      else if ((m + 1) % 2)  nl = 11;
      else                   nl = 9;
      ref_edge_send(1, m == 26, 0, nl);
    end

    // Bad runs broken by a good measurement never unlock.
    for (int k = 0; k < 8; k++) ref_edge_send(1, 1, 0, (k < 7) ? d_seq[k + 1] : 0);

    // Reference stuck low: four timeouts unlock, period_count frozen.
    e.meas = 1'b0; e.period = '0; e.lk = 1'b0; e.ll = 1'b1;
    exp_q.push_back(e);
    cycles(270);
    check("timeout_locked", 32'(locked), 0);
    check("timeout_period_frozen", 32'(period_count), 10);
    check("timeout_queue_drained", 32'(exp_q.size()), 0);

    // Disable from ACQUIRE clears period_count.
    enable = 1'b0;
    cycles(2);
    check("dis_acq_period", 32'(period_count), 0);
    check("dis_acq_locked", 32'(locked), 0);
    enable = 1'b1;
    cycles(3);

    // Relock through ARM, then drop enable while locked.
    ref_edge_send(0, 0, 0, 10);
    for (int i = 1; i <= 16; i++) ref_edge_send(1, i == 16, 0, (i == 16) ? 0 : 10);
    cycles(6);
    check("relock_locked", 32'(locked), 1);
    enable = 1'b0;
    cycles(1);
    check("dis_lk_locked", 32'(locked), 0);
    check("dis_lk_period", 32'(period_count), 0);
    check("dis_lk_lock_lost", 32'(lock_lost), 0);
    check("dis_lk_meas_valid", 32'(meas_valid), 0);
    enable = 1'b1;
    cycles(3);
    ref_edge_send(0, 0, 0, 10);
    ref_edge_send(1, 0, 0, 10);
    ref_edge_send(1, 0, 0, 10);
    ref_edge_send(1, 0, 0, 0);
    cycles(6);
    check("rearm_period", 32'(period_count), 10);

    // Asynchronous reset between clock edges clears outputs immediately.
    @(negedge clk_in);
    #2 rst_n = 1'b0;
    #1 check("async_rst_period", 32'(period_count), 0);
    check("async_rst_locked", 32'(locked), 0);
    cycles(2);
    rst_n = 1'b1;
    cycles(3);
    ref_edge_send(0, 0, 0, 10);
    ref_edge_send(1, 0, 0, 0);
    cycles(8);
    check("final_queue_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
